byte_serial_add_arbiter: RTL and testbench

- Shares one 8-bit adder slice with carry-in/carry-out between two requesters.
- Each request adds two NBYTES-byte operands, least-significant byte first, one byte per clock.
- Round-robin arbitration between the requesters; a valid/ready handshake on every channel.
- Sits between the byte-wide add datapath and the blocks that need wide sums. It also reports the reduction-AND (all ones) of operand B.

---
 rtl/byte_serial_add_pkg.sv | 13 +
 rtl/add8_cin.sv | 13 +
 rtl/byte_serial_add_arbiter.sv | 129 ++++++++++++
 tb/tb_byte_serial_add_arbiter.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/byte_serial_add_pkg.sv
// Shared types and widths for the byte-serial add arbiter.
package byte_serial_add_pkg;

    localparam int unsigned BYTE_W   = 8;
    localparam int unsigned REQ_ID_W = 1;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

endpackage

// File: rtl/add8_cin.sv
// Combinational byte adder with carry-in; the single shared adder slice.
module add8_cin
    import byte_serial_add_pkg::*;
(
    input  logic [BYTE_W-1:0] a_i,
    input  logic [BYTE_W-1:0] b_i,
    input  logic              cin_i,
    output logic [BYTE_W:0]   result_o
);

    assign result_o = {1'b0, a_i} + {1'b0, b_i} + {{BYTE_W{1'b0}}, cin_i};

endmodule

// File: rtl/byte_serial_add_arbiter.sv
// Two-requester round-robin arbiter in front of a byte-serial wide adder.
module byte_serial_add_arbiter
    import byte_serial_add_pkg::*;
#(
    parameter int unsigned NBYTES = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req0_valid,
    output logic                     req0_ready,
    input  logic [BYTE_W*NBYTES-1:0] req0_a,
    input  logic [BYTE_W*NBYTES-1:0] req0_b,
    input  logic                     req0_cin,
    input  logic                     req1_valid,
    output logic                     req1_ready,
    input  logic [BYTE_W*NBYTES-1:0] req1_a,
    input  logic [BYTE_W*NBYTES-1:0] req1_b,
    input  logic                     req1_cin,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [BYTE_W*NBYTES-1:0] rsp_sum,
    output logic                     rsp_cout,
    output logic                     rsp_id,
    output logic                     rsp_all_ones_b,
    output logic                     busy
);

    localparam int unsigned IdxW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NBYTES - 1);

    state_e state_q, state_d;

    logic [NBYTES-1:0][BYTE_W-1:0] a_q, b_q, sum_q;
    logic [IdxW-1:0]               idx_q;
    logic                          carry_q;
    logic                          cout_q;
    logic                          all_ones_q;
    logic [REQ_ID_W-1:0]           id_q;
    logic [REQ_ID_W-1:0]           last_grant_q;
    logic [REQ_ID_W-1:0]           grant;
    logic                          accept;
    logic                          last_byte;
    logic [BYTE_W:0]               add_res;

    // A tie goes to whichever requester was not served last.
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = ~last_grant_q;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
    end

    assign req0_ready = (state_q == StIdle) && (grant == 1'b0) && req0_valid;
    assign req1_ready = (state_q == StIdle) && (grant == 1'b1) && req1_valid;
    assign accept     = req0_ready | req1_ready;
    assign last_byte  = (idx_q == LastIdx);

    add8_cin u_add8_cin (
        .a_i      (a_q[idx_q]),
        .b_i      (b_q[idx_q]),
        .cin_i    (carry_q),
        .result_o (add_res)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (accept) state_d = StRun;
            StRun:  if (last_byte) state_d = StDone;
            StDone: if (rsp_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q          <= '0;
            b_q          <= '0;
            sum_q        <= '0;
            idx_q        <= '0;
            carry_q      <= 1'b0;
            cout_q       <= 1'b0;
            all_ones_q   <= 1'b0;
            id_q         <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        a_q          <= grant ? req1_a : req0_a;
                        b_q          <= grant ? req1_b : req0_b;
                        carry_q      <= grant ? req1_cin : req0_cin;
                        idx_q        <= '0;
                        id_q         <= grant;
                        last_grant_q <= grant;
                    end
                end
                StRun: begin
                    sum_q[idx_q] <= add_res[BYTE_W-1:0];
                    carry_q      <= add_res[BYTE_W];
                    idx_q        <= idx_q + IdxW'(1);
                    if (last_byte) begin
                        cout_q     <= add_res[BYTE_W];
                        all_ones_q <= &b_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rsp_valid      = (state_q == StDone);
    assign rsp_sum        = sum_q;
    assign rsp_cout       = cout_q;
    assign rsp_id         = id_q;
    assign rsp_all_ones_b = all_ones_q;
    assign busy           = (state_q != StIdle);

endmodule

// File: tb/tb_byte_serial_add_arbiter.sv
// Directed self-checking bench: NBYTES=4 main instance plus an NBYTES=1 instance.
module tb_byte_serial_add_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready, req0_cin;
    logic        req1_valid, req1_ready, req1_cin;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        rsp_valid, rsp_ready, rsp_cout, rsp_id, rsp_all_ones_b, busy;
    logic [31:0] rsp_sum;

    logic       d1_req0_valid, d1_req0_ready, d1_req1_ready, d1_rsp_valid;
    logic       d1_rsp_cout, d1_rsp_id, d1_rsp_all_ones_b, d1_busy;
    logic [7:0] d1_req0_a, d1_req0_b, d1_rsp_sum;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    byte_serial_add_arbiter #(.NBYTES(4)) u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req0_valid     (req0_valid),
        .req0_ready     (req0_ready),
        .req0_a         (req0_a),
        .req0_b         (req0_b),
        .req0_cin       (req0_cin),
        .req1_valid     (req1_valid),
        .req1_ready     (req1_ready),
        .req1_a         (req1_a),
        .req1_b         (req1_b),
        .req1_cin       (req1_cin),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_sum        (rsp_sum),
        .rsp_cout       (rsp_cout),
        .rsp_id         (rsp_id),
        .rsp_all_ones_b (rsp_all_ones_b),
        .busy           (busy)
    );

    byte_serial_add_arbiter #(.NBYTES(1)) u_dut1 (
        .clk            (clk),
        .rst_n          (rst_n),
        .req0_valid     (d1_req0_valid),
        .req0_ready     (d1_req0_ready),
        .req0_a         (d1_req0_a),
        .req0_b         (d1_req0_b),
        .req0_cin       (1'b0),
        .req1_valid     (1'b0),
        .req1_ready     (d1_req1_ready),
        .req1_a         (8'h00),
        .req1_b         (8'h00),
        .req1_cin       (1'b0),
        .rsp_valid      (d1_rsp_valid),
        .rsp_ready      (1'b1),
        .rsp_sum        (d1_rsp_sum),
        .rsp_cout       (d1_rsp_cout),
        .rsp_id         (d1_rsp_id),
        .rsp_all_ones_b (d1_rsp_all_ones_b),
        .busy           (d1_busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue one operation on the 4-byte instance; returns at the first negedge with rsp_valid.
    task automatic run_op(input int r, input logic [31:0] a, input logic [31:0] b,
                          input logic cin, output int lat);
        if (r == 0) begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_cin = cin;
        end else begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_cin = cin;
        end
        #1;
        check(r == 0 ? "req0_ready" : "req1_ready", r == 0 ? req0_ready : req1_ready, 1);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        int g_time[$];
        int g_id[$];
        int r_id[$];
        logic [31:0] r_sum[$];
        int both;

        rst_n = 1'b0; rsp_ready = 1'b1;
        req0_valid = 0; req0_a = 0; req0_b = 0; req0_cin = 0;
        req1_valid = 0; req1_a = 0; req1_b = 0; req1_cin = 0;
        d1_req0_valid = 0; d1_req0_a = 0; d1_req0_b = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        check("rst_valid", rsp_valid, 0);
        check("rst_sum", rsp_sum, 0);
        check("rst_cout", rsp_cout, 0);
        check("rst_id", rsp_id, 0);
        check("rst_all_ones", rsp_all_ones_b, 0);
        check("rst_busy", busy, 0);

        // Basic add, rsp_ready held high throughout.
        run_op(0, 32'h0000_00FF, 32'h0000_009B, 1'b0, lat);
        check("t1_lat", lat, 4);
        check("t1_sum", rsp_sum, 32'h0000_019A);
        check("t1_cout", rsp_cout, 0);
        check("t1_id", rsp_id, 0);
        check("t1_all_ones", rsp_all_ones_b, 0);
        @(negedge clk);
        check("t1_idle", busy, 0);

        run_op(0, 32'h0000_00FF, 32'h0000_009B, 1'b1, lat);
        check("t2_sum", rsp_sum, 32'h0000_019B);
        @(negedge clk);

        run_op(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, lat);
        check("t3_sum", rsp_sum, 32'hFFFF_FFFF);
        check("t3_cout", rsp_cout, 1);
        check("t3_all_ones", rsp_all_ones_b, 1);
        check("t3_id", rsp_id, 1);
        @(negedge clk);

        // Round robin with both requesters permanently valid.
        req0_valid = 1; req0_a = 32'h1;  req0_b = 32'h2;  req0_cin = 0;
        req1_valid = 1; req1_a = 32'h10; req1_b = 32'h20; req1_cin = 0;
        both = 0;
        for (int i = 0; i < 26; i++) begin
            #1;
            if (req0_ready && req1_ready) both++;
            if (req0_ready) begin g_time.push_back(i); g_id.push_back(0); end
            if (req1_ready) begin g_time.push_back(i); g_id.push_back(1); end
            if (rsp_valid) begin r_id.push_back(int'(rsp_id)); r_sum.push_back(rsp_sum); end
            @(negedge clk);
        end
        req0_valid = 0; req1_valid = 0;
        check("rr_both_ready", both, 0);
        check("rr_grants", g_id.size(), 5);
        for (int k = 0; k < 4; k++) begin
            if (g_id.size() > k) begin
                check($sformatf("rr_id%0d", k), g_id[k], k % 2);
                check($sformatf("rr_time%0d", k), g_time[k], k * 6);
            end
        end
        check("rr_rsps", r_id.size(), 4);
        if (r_id.size() >= 2) begin
            check("rr_rsp0_id", r_id[0], 0);
            check("rr_rsp0_sum", r_sum[0], 32'h3);
            check("rr_rsp1_id", r_id[1], 1);
            check("rr_rsp1_sum", r_sum[1], 32'h30);
        end
        lat = 0;
        while (busy && lat < 50) begin @(negedge clk); lat++; end
        check("rr_drain", busy, 0);

        // Consumer stalls for 5 cycles in DONE while requester 1 waits.
        rsp_ready = 0;
        run_op(0, 32'h1234_5678, 32'h1111_1111, 1'b0, lat);
        check("st_lat", lat, 4);
        req1_valid = 1; req1_a = 32'h5; req1_b = 32'h6;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("st_valid", rsp_valid, 1);
            check("st_sum", rsp_sum, 32'h2345_6789);
            check("st_ready0", req0_ready, 0);
            check("st_ready1", req1_ready, 0);
            @(negedge clk);
        end
        rsp_ready = 1;
        @(negedge clk);
        #1;
        check("st_idle", busy, 0);
        check("st_valid_clr", rsp_valid, 0);
        check("st_ready1_idle", req1_ready, 1);
        req1_valid = 0;
        @(negedge clk);

        // Abort with reset after the second RUN byte.
        req0_valid = 1; req0_a = 32'hAAAA_AAAA; req0_b = 32'h5555_5555; req0_cin = 0;
        @(negedge clk);
        req0_valid = 0;
        repeat (2) @(negedge clk);
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        check("ab_busy", busy, 0);
        check("ab_valid", rsp_valid, 0);
        check("ab_sum", rsp_sum, 0);
        check("ab_cout", rsp_cout, 0);
        check("ab_id", rsp_id, 0);
        check("ab_all_ones", rsp_all_ones_b, 0);
        req1_valid = 1; req1_a = 32'h7; req1_b = 32'h8;
        req0_valid = 1; req0_a = 32'h00FF_00FF; req0_b = 32'h0001_0001;
        #1;
        check("ab_tie0", req0_ready, 1);
        check("ab_tie1", req1_ready, 0);
        run_op(0, 32'h00FF_00FF, 32'h0001_0001, 1'b0, lat);
        check("ab_sum2", rsp_sum, 32'h0100_0100);
        check("ab_id2", rsp_id, 0);
        @(negedge clk);

        // Single-byte instance.
        d1_req0_valid = 1; d1_req0_a = 8'hFF; d1_req0_b = 8'h9B;
        #1;
        check("n1_ready", d1_req0_ready, 1);
        @(negedge clk);
        d1_req0_valid = 0;
        lat = 0;
        while (!d1_rsp_valid && lat < 50) begin @(negedge clk); lat++; end
        check("n1_lat", lat, 1);
        check("n1_sum", d1_rsp_sum, 8'h9A);
        check("n1_cout", d1_rsp_cout, 1);
        @(negedge clk);
        check("n1_idle", d1_busy, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
